// File: rtl/fragment_pkt_pkg.sv
// Shared definitions for the packet fragmenter and the reassembly side:
// packet field widths, FSM encoding and a ceiling-divide helper.
package fragment_pkt_pkg;

    localparam int unsigned DATA_WIDTH   = 1024;
    localparam int unsigned ADDR_WIDTH   = 10;
    localparam int unsigned ACK_WIDTH    = 1;
    localparam int unsigned SEQ_WIDTH    = 1;
    localparam int unsigned DFX_ID_WIDTH = 2;

    // Encapsulated packet: data, addr, ack, two seq bits, two dfx ids.
    localparam int unsigned PKT_WIDTH_DEF =
        DATA_WIDTH + ADDR_WIDTH + ACK_WIDTH + 2 * SEQ_WIDTH + 2 * DFX_ID_WIDTH;

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } frag_state_e;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/frag_lane_slice.sv
// Selects one lane's slice of the current beat from a packet, zero-padding
// any bits that fall beyond the end of the packet.
module frag_lane_slice
    import fragment_pkt_pkg::*;
#(
    parameter int unsigned PKT_WIDTH    = 1041,
    parameter int unsigned AURORA_WIDTH = 256,
    parameter int unsigned NUM_LANES    = 4,
    parameter int unsigned LANE         = 0,
    parameter int unsigned CNT_WIDTH    = 2
) (
    input  logic [PKT_WIDTH-1:0]    pkt,
    input  logic [CNT_WIDTH-1:0]    beat,
    input  logic                    en,
    output logic [AURORA_WIDTH-1:0] data
);

    localparam int unsigned BEAT_BITS = NUM_LANES * AURORA_WIDTH;
    localparam int unsigned PAD_WIDTH = ceil_div(PKT_WIDTH, BEAT_BITS) * BEAT_BITS;
    localparam int unsigned OFF_WIDTH = (PAD_WIDTH > 1) ? $clog2(PAD_WIDTH) : 1;

    logic [PAD_WIDTH-1:0] padded;
    logic [OFF_WIDTH-1:0] offset;

    always_comb begin
        padded = PAD_WIDTH'(pkt);
        offset = OFF_WIDTH'((32'(beat) * NUM_LANES + LANE) * AURORA_WIDTH);
        data   = en ? padded[offset +: AURORA_WIDTH] : '0;
    end

endmodule

// File: rtl/fragment_pkt_stripe.sv
// Splits one wide packet into NUM_BEATS beats striped across NUM_LANES
// Aurora lanes; a new packet may be accepted on the final beat's fire.
module fragment_pkt_stripe
    import fragment_pkt_pkg::*;
#(
    parameter int unsigned PKT_WIDTH    = PKT_WIDTH_DEF,
    parameter int unsigned AURORA_WIDTH = 256,
    parameter int unsigned NUM_LANES    = 4,
    parameter int unsigned DFX_WIDTH    = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              valid_pkt_send,
    output logic                              pkt_ready,
    input  logic [PKT_WIDTH-1:0]              pkt_data,
    input  logic [DFX_WIDTH-1:0]              pkt_src_dfx,
    output logic [NUM_LANES*AURORA_WIDTH-1:0] lane_tdata,
    output logic [NUM_LANES-1:0]              lane_tvalid,
    input  logic [NUM_LANES-1:0]              lane_tready,
    output logic                              lane_tlast,
    output logic [DFX_WIDTH-1:0]              lane_dfx,
    output logic                              frag_done
);

    localparam int unsigned BEAT_BITS  = NUM_LANES * AURORA_WIDTH;
    localparam int unsigned NUM_BEATS  = ceil_div(PKT_WIDTH, BEAT_BITS);
    localparam int unsigned CNT_WIDTH  = $clog2(NUM_BEATS) + 1;
    localparam int unsigned LAST_LANES =
        ceil_div(PKT_WIDTH - (NUM_BEATS - 1) * BEAT_BITS, AURORA_WIDTH);
    localparam logic [NUM_LANES-1:0] LAST_MASK =
        {NUM_LANES{1'b1}} >> (NUM_LANES - LAST_LANES);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(NUM_BEATS - 1);

    frag_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0]  beat_q, beat_d;
    logic [PKT_WIDTH-1:0]  pkt_q;
    logic [DFX_WIDTH-1:0]  dfx_q;
    logic                  done_q;

    logic                  sending;
    logic                  last_beat;
    logic                  beat_fire;
    logic                  final_fire;
    logic                  accept;

    always_comb begin
        sending     = (state_q == StSend);
        last_beat   = (beat_q == LAST_BEAT);
        lane_tvalid = '0;
        if (sending) begin
            lane_tvalid = last_beat ? LAST_MASK : '1;
        end
        // Lanes not carrying data this beat do not gate the fire.
        beat_fire  = sending && ((lane_tready & lane_tvalid) == lane_tvalid);
        final_fire = beat_fire && last_beat;
        pkt_ready  = !sending || final_fire;
        accept     = valid_pkt_send && pkt_ready;
        lane_tlast = sending && last_beat;
        lane_dfx   = dfx_q;
        frag_done  = done_q;
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StSend;
                    beat_d  = '0;
                end
            end
            StSend: begin
                if (final_fire) begin
                    beat_d  = '0;
                    state_d = accept ? StSend : StIdle;
                end else if (beat_fire) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            beat_q  <= '0;
            pkt_q   <= '0;
            dfx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            done_q  <= final_fire;
            if (accept) begin
                pkt_q <= pkt_data;
                dfx_q <= pkt_src_dfx;
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        frag_lane_slice #(
            .PKT_WIDTH    (PKT_WIDTH),
            .AURORA_WIDTH (AURORA_WIDTH),
            .NUM_LANES    (NUM_LANES),
            .LANE         (i),
            .CNT_WIDTH    (CNT_WIDTH)
        ) u_slice (
            .pkt  (pkt_q),
            .beat (beat_q),
            .en   (sending),
            .data (lane_tdata[i*AURORA_WIDTH +: AURORA_WIDTH])
        );
    end

endmodule

// File: doc/fragment_pkt_stripe.md
FRAGMENT_PKT_STRIPE -- requirements
Module: fragment_pkt_stripe

Interface
REQ-001 SHALL have parameter PKT_WIDTH, default 1041, meaning width of an encapsulated packet (DATA 1024 + ADDR 10 + ACK 1 + 2×SEQ 1 + 2×DFX 2).
REQ-002 SHALL have parameter AURORA_WIDTH, default 256, meaning bits per lane per beat.
REQ-003 SHALL have parameter NUM_LANES, default 4, meaning number of parallel Aurora lanes.
REQ-004 SHALL have parameter DFX_WIDTH, default 2, meaning source DFX id width.
REQ-005 SHALL have derived localparam BEAT_BITS = NUM_LANES*AURORA_WIDTH, meaning bits carried per beat.
REQ-006 SHALL have derived localparam NUM_BEATS = ceil(PKT_WIDTH/BEAT_BITS), meaning beats per packet (default 2).
REQ-007 SHALL have derived localparam LAST_MASK, meaning lanes carrying data in the final beat (default 4'b0001).
REQ-008 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-009 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-010 SHALL have port valid_pkt_send  in  1  input packet valid.
REQ-011 SHALL have port pkt_ready  out  1  module accepts the packet this cycle.
REQ-012 SHALL have port pkt_data  in  PKT_WIDTH  packet to fragment.
REQ-013 SHALL have port pkt_src_dfx  in  DFX_WIDTH  source DFX id, captured with the packet.
REQ-014 SHALL have port lane_tdata  out  BEAT_BITS  lane i occupies bits [i*AURORA_WIDTH +: AURORA_WIDTH].
REQ-015 SHALL have port lane_tvalid  out  NUM_LANES  per-lane valid.
REQ-016 SHALL have port lane_tready  in  NUM_LANES  per-lane ready.
REQ-017 SHALL have port lane_tlast  out  1  final beat of a packet.
REQ-018 SHALL have port lane_dfx  out  DFX_WIDTH  captured source id, stable for the whole packet.
REQ-019 SHALL have port frag_done  out  1  one-cycle pulse after a packet's final beat.

Function
REQ-020 SHALL accept a packet on valid_pkt_send && pkt_ready, registering pkt_data and pkt_src_dfx.
REQ-021 SHALL drive pkt_ready = (state==IDLE) || (final beat firing this cycle), permitting back-to-back packets with no bubble.
REQ-022 SHALL use an FSM with states IDLE and SEND.
REQ-023 SHALL transition IDLE->SEND on accept.
REQ-024 SHALL stay in SEND while a beat is pending.
REQ-025 SHALL transition SEND->IDLE on final-beat fire with no new accept, and SHALL stay in SEND with beat counter cleared on final-beat fire with an accept.
REQ-026 SHALL map beat k, lane i to packet bits [(k*NUM_LANES+i)*AURORA_WIDTH +: AURORA_WIDTH], LSB first; bits beyond PKT_WIDTH SHALL be zero.
REQ-027 SHALL drive lane_tvalid = all-ones on non-final beats and LAST_MASK on the final beat, and zero in IDLE.
REQ-028 SHALL fire a beat only when (lane_tready & lane_tvalid) == lane_tvalid; lanes with tvalid=0 SHALL be ignored.
REQ-029 SHALL hold data, valid and tlast stable while a beat is stalled.
REQ-030 SHALL set lane_tlast only when beat counter == NUM_BEATS-1; if NUM_BEATS==1, every beat SHALL be last.
REQ-031 SHALL use a beat counter of width clog2(NUM_BEATS)+1 that resets to 0 on each accept and never wraps past NUM_BEATS-1.
REQ-032 SHALL assert frag_done for exactly one cycle, in the cycle after a final-beat fire.
REQ-033 SHALL take one cycle from accept to first lane_tvalid.

Reset
REQ-034 SHALL set, on rst=1 at a clock edge: state IDLE, beat counter 0, lane_tvalid 0, lane_tlast 0, lane_tdata 0, lane_dfx 0, frag_done 0.
REQ-035 SHALL hold pkt_ready 1 in the first cycle after reset deasserts.
REQ-036 SHALL discard any in-flight packet when reset is asserted mid-packet, emitting no further beats and no frag_done.

Structure
REQ-037 SHALL keep PKT_WIDTH derivation, the FSM state encoding and a ceiling-divide function in a shared package/header (fragment_pkt_pkg) also used by the reassembly side.
REQ-038 SHALL implement the per-lane beat slice/zero-pad as sub-module frag_lane_slice, instantiated NUM_LANES times via generate.

Verification
REQ-039 SHALL verify defaults with all ready, pkt_data = incrementing bytes: 2 beats; beat0 tvalid=4'b1111, beat1 tvalid=4'b0001, tlast=1, lane0 holds bits [1040:1024] zero-padded; frag_done one cycle later.
REQ-040 SHALL verify stall: lane_tready=4'b1101 on beat0 for 5 cycles: tdata/tvalid unchanged for 5 cycles, then the beat fires.
REQ-041 SHALL verify that on beat1, lane_tready=4'b0001 fires the beat (lanes 1–3 ignored).
REQ-042 SHALL verify two packets with valid_pkt_send held high: 4 consecutive beats, no idle cycle, lane_dfx switching at beat 2.
REQ-043 SHALL verify rst pulse during beat0 stall: next cycle lane_tvalid=0, pkt_ready=1, no frag_done.
REQ-044 SHALL verify NUM_LANES=1, AURORA_WIDTH=64, PKT_WIDTH=128: 2 beats of 64 bits each, tvalid=1'b1 on both beats.
